fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Fetch-stage next-PC generator, directly downstream of branch_target_buffer.
- Drives the fetch PC into the BTB and instruction memory, then consumes the BTB's registered predicted_branch_pc one cycle later. On a predicted-taken hit it steers fetch to the target.
- Keeps an in-order FIFO of (fetched PC, predicted next PC) pairs. Execute pops an entry on each resolution and uses it for misprediction checks.

Parameters:
- RESET_PC, 64'h0, PC loaded on reset.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- en  in  1  fetch allowed (downstream ready)
- predicted_branch_pc  in  64  BTB output; 0 = no prediction; applies to pc issued previous cycle
- redirect_valid  in  1  execute misprediction/redirect
- redirect_pc  in  64  correct PC on redirect
- resolve_valid  in  1  execute consumed FIFO head
- pc  out  64  current fetch PC (to BTB current_pc and imem)
- fetch_valid  out  1  pc is a valid fetch this cycle (to BTB en)
- q_valid  out  1  FIFO non-empty
- q_pc  out  64  head entry fetched PC
- q_pred_pc  out  64  head entry predicted next PC
- q_count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- State: pc_q, pc_prev_q, prev_valid_q (fetch issued last cycle), FIFO (head/tail pointers wrap modulo DEPTH, count).
- Reset (sync, highest priority):
  - pc_q = RESET_PC; prev_valid_q = 0; FIFO emptied.
  - Outputs: fetch_valid = 0, q_valid = 0, q_count = 0, q_pc = 0, q_pred_pc = 0.
- Combinational terms:
  - seq = pc_prev_q + 64'd4, wrapping modulo 2^64.
  - take = prev_valid_q & (predicted_branch_pc != 0) & (predicted_branch_pc != seq).
  - pred_next = take ? predicted_branch_pc : seq.
  - full_stall = (q_count + prev_valid_q) >= DEPTH. This is conservative: a same-cycle pop is ignored.
  - fetch_valid = en & ~redirect_valid & ~take & ~full_stall.
- Push: when prev_valid_q & ~redirect_valid, push {pc_prev_q, pred_next}. Each instruction is enqueued one cycle after its fetch, once its BTB result is known.
- Pop: when resolve_valid & q_valid & ~redirect_valid. resolve_valid on an empty FIFO is ignored.
- Push and pop in the same cycle: q_count unchanged; both pointers advance.
- Next-PC priority (applied at clock edge, rst aside):
  1. redirect_valid:
     - pc_q <= redirect_pc; FIFO flushed (count 0, pointers reset).
     - prev_valid_q <= 0; the pending push is dropped.
  2. take:
     - pc_q <= predicted_branch_pc; prev_valid_q <= 0.
     - The sequential fetch this cycle is squashed (fetch_valid = 0).
  3. fetch_valid:
     - pc_q <= pc_q + 4; pc_prev_q <= pc_q; prev_valid_q <= 1.
  4. Otherwise (en = 0 or full_stall): pc_q holds; prev_valid_q <= 0.
- A pending push still occurs when en = 0 or on a stall.
- Latency:
  - Predicted-taken branch costs exactly one bubble.
  - Redirect costs one bubble; the first fetch at redirect_pc comes the cycle after redirect_valid.
- q_pc / q_pred_pc:
  - Read combinationally from the head entry.
  - Driven to 0 when the FIFO is empty.
- Integration: BTB en = fetch_valid, BTB current_pc = pc.

Test Plan:
- Reset, en = 1, predicted = 0 (DEPTH = 4):
  - fetch_valid = 1 with pc 0x0, 0x4, 0x8, 0xC in cycles 1–4.
  - Cycle 5: fetch_valid = 0, pc holds 0x10.
  - After cycle 5: q_count = 4, head = (0x0, 0x4).
  - resolve_valid one cycle → fetch 0x10 resumes next cycle.
- Fetch 0x20 at cycle N, predicted_branch_pc = 0x100 at N+1:
  - N+1: fetch_valid = 0 (0x24 squashed); entry (0x20, 0x100) pushed.
  - N+2: pc = 0x100, fetch_valid = 1.
- Fetch 0x40, predicted_branch_pc = 0x44 next cycle → no squash; entry (0x40, 0x44); pc advances 0x44 → 0x48.
- With 3 entries queued, redirect_valid = 1, redirect_pc = 0x200, resolve_valid = 1 same cycle:
  - Next cycle: q_count = 0, q_valid = 0, pc = 0x200, fetch_valid = 1.
  - Redirect cycle: fetch_valid = 0.
- Simultaneous push and pop with q_count = 2 → q_count stays 2, head advances. resolve_valid on an empty FIFO → q_count stays 0, no pointer change.
- rst and redirect_valid asserted together mid-run → pc = RESET_PC, FIFO empty, fetch_valid = 0; first fetch of RESET_PC the cycle after rst deasserts.

Source files
------------

// File: rtl/fetch_pc_if.sv
// Fetch-side bus of fetch_pc_unit: BTB prediction in, execute redirect/resolve in,
// fetch PC and the in-order (PC, predicted next PC) queue head out.
interface fetch_pc_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          en;
  logic [63:0]   predicted_branch_pc;
  logic          redirect_valid;
  logic [63:0]   redirect_pc;
  logic          resolve_valid;
  logic [63:0]   pc;
  logic          fetch_valid;
  logic          q_valid;
  logic [63:0]   q_pc;
  logic [63:0]   q_pred_pc;
  logic [CW-1:0] q_count;

  modport master (
    output en, predicted_branch_pc, redirect_valid, redirect_pc, resolve_valid,
    input  pc, fetch_valid, q_valid, q_pc, q_pred_pc, q_count
  );

  modport slave (
    input  en, predicted_branch_pc, redirect_valid, redirect_pc, resolve_valid,
    output pc, fetch_valid, q_valid, q_pc, q_pred_pc, q_count
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch-stage next-PC generator: sequential fetch, one-bubble steering on BTB
// predicted-taken hits, redirect flush, and an in-order prediction FIFO for execute.
module fetch_pc_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 4
) (
  input logic       clk,
  input logic       rst,
  fetch_pc_if.slave bus
);
  localparam int              AW       = $clog2(DEPTH);
  localparam int              CW       = AW + 1;
  localparam logic [CW:0]     DEPTH_W  = (CW+1)'(DEPTH);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  logic [63:0]   pc_r;
  logic [63:0]   pc_prev_r;
  logic          prev_valid_r;
  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [CW-1:0] count_r;
  logic [63:0]   fifo_pc_r   [DEPTH];
  logic [63:0]   fifo_pred_r [DEPTH];

  logic [63:0]   seq_s;
  logic [63:0]   pred_next_s;
  logic          take_s;
  logic          full_stall_s;
  logic          nonempty_s;
  logic          fetch_valid_s;
  logic          push_s;
  logic          pop_s;

  // The BTB answer refers to pc_prev_r; a target equal to the fall-through is not a steer.
  assign seq_s         = pc_prev_r + 64'd4;
  assign take_s        = prev_valid_r & (bus.predicted_branch_pc != 64'd0)
                       & (bus.predicted_branch_pc != seq_s);
  assign pred_next_s   = take_s ? bus.predicted_branch_pc : seq_s;
  // Reserve a slot for the instruction fetched last cycle; a same-cycle pop is not credited.
  assign full_stall_s  = ({1'b0, count_r} + {{CW{1'b0}}, prev_valid_r}) >= DEPTH_W;
  assign nonempty_s    = (count_r != {CW{1'b0}});
  assign fetch_valid_s = ~rst & bus.en & ~bus.redirect_valid & ~take_s & ~full_stall_s;
  assign push_s        = ~rst & prev_valid_r & ~bus.redirect_valid;
  assign pop_s         = ~rst & bus.resolve_valid & nonempty_s & ~bus.redirect_valid;

  assign bus.pc          = pc_r;
  assign bus.fetch_valid = fetch_valid_s;
  assign bus.q_valid     = ~rst & nonempty_s;
  assign bus.q_pc        = (~rst & nonempty_s) ? fifo_pc_r[head_r]   : 64'd0;
  assign bus.q_pred_pc   = (~rst & nonempty_s) ? fifo_pred_r[head_r] : 64'd0;
  assign bus.q_count     = rst ? {CW{1'b0}} : count_r;

  // FIFO payload storage, written at the tail on every accepted push.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_pc_r[tail_r]   <= pc_prev_r;
      fifo_pred_r[tail_r] <= pred_next_s;
    end else begin
      fifo_pc_r[tail_r]   <= fifo_pc_r[tail_r];
      fifo_pred_r[tail_r] <= fifo_pred_r[tail_r];
    end
  end

  // PC sequencing and FIFO bookkeeping; reset, then redirect, then taken, then fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r         <= RESET_PC;
      pc_prev_r    <= 64'd0;
      prev_valid_r <= 1'b0;
      head_r       <= {AW{1'b0}};
      tail_r       <= {AW{1'b0}};
      count_r      <= {CW{1'b0}};
    end else if (bus.redirect_valid) begin
      pc_r         <= bus.redirect_pc;
      prev_valid_r <= 1'b0;
      head_r       <= {AW{1'b0}};
      tail_r       <= {AW{1'b0}};
      count_r      <= {CW{1'b0}};
    end else begin
      if (push_s) tail_r <= tail_r + PTR_ONE;
      else        tail_r <= tail_r;
      if (pop_s)  head_r <= head_r + PTR_ONE;
      else        head_r <= head_r;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      if (take_s) begin
        pc_r         <= bus.predicted_branch_pc;
        prev_valid_r <= 1'b0;
      end else if (fetch_valid_s) begin
        pc_r         <= pc_r + 64'd4;
        pc_prev_r    <= pc_r;
        prev_valid_r <= 1'b1;
      end else begin
        pc_r         <= pc_r;
        prev_valid_r <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: a queue-based instruction-stream model predicts
// every cycle's outputs; a negedge monitor pops and compares them.
module tb_fetch_pc_unit;
  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_pc_if #(.DEPTH(DEPTH)) bus ();
  fetch_pc_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [63:0] pc;
    logic [63:0] pred;
  } entry_t;

  typedef struct {
    bit          fv;
    bit          chk_pc;
    logic [63:0] pc;
    bit          qv;
    int          qc;
    logic [63:0] qpc;
    logic [63:0] qpred;
  } exp_t;

  entry_t      m_q[$];
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [63:0] m_pc;
  logic [63:0] m_last;
  bit          m_last_v;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: the stream of fetched instructions and their queued predictions.
  task automatic model_step(input bit r, input bit en, input logic [63:0] pb,
                            input bit rd, input logic [63:0] rpc, input bit rs);
    exp_t        e;
    logic [63:0] nxt;
    bit          take;
    bit          full;
    e.fv = 1'b0; e.chk_pc = 1'b0; e.pc = 64'd0; e.qv = 1'b0; e.qc = 0;
    e.qpc = 64'd0; e.qpred = 64'd0;
    if (r) begin
      exp_q.push_back(e);
      m_pc = RESET_PC;
      m_last_v = 1'b0;
      m_q.delete();
    end else begin
      nxt  = m_last + 64'd4;
      take = m_last_v && (pb != 64'd0) && (pb != nxt);
      full = (m_q.size() + (m_last_v ? 1 : 0)) >= DEPTH;
      e.fv = en && !rd && !take && !full;
      e.chk_pc = 1'b1;
      e.pc = m_pc;
      e.qc = m_q.size();
      e.qv = (m_q.size() > 0);
      if (m_q.size() > 0) begin
        e.qpc = m_q[0].pc;
        e.qpred = m_q[0].pred;
      end
      exp_q.push_back(e);
      if (rd) begin
        m_q.delete();
        m_pc = rpc;
        m_last_v = 1'b0;
      end else begin
        if (rs && m_q.size() > 0) void'(m_q.pop_front());
        if (m_last_v) m_q.push_back('{pc: m_last, pred: (take ? pb : nxt)});
        if (take) begin
          m_pc = pb;
          m_last_v = 1'b0;
        end else if (e.fv) begin
          m_last = m_pc;
          m_pc = m_pc + 64'd4;
          m_last_v = 1'b1;
        end else begin
          m_last_v = 1'b0;
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit en, input logic [63:0] pb,
                     input bit rd, input logic [63:0] rpc, input bit rs);
    @(posedge clk);
    #1;
    rst = r;
    bus.en = en;
    bus.predicted_branch_pc = pb;
    bus.redirect_valid = rd;
    bus.redirect_pc = rpc;
    bus.resolve_valid = rs;
    model_step(r, en, pb, rd, rpc, rs);
  endtask

  // Monitor: the DUT presents a full output set every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("fetch_valid", 64'(bus.fetch_valid), 64'(mon_e.fv));
      if (mon_e.chk_pc) check("pc", bus.pc, mon_e.pc);
      check("q_valid", 64'(bus.q_valid), 64'(mon_e.qv));
      check("q_count", 64'(bus.q_count), 64'(mon_e.qc));
      check("q_pc", bus.q_pc, mon_e.qpc);
      check("q_pred_pc", bus.q_pred_pc, mon_e.qpred);
    end
  end

  initial begin
    logic [63:0] pb;
    logic [63:0] rpc;
    int          sel;
    rst = 1'b1;
    bus.en = 1'b0; bus.predicted_branch_pc = 64'd0; bus.redirect_valid = 1'b0;
    bus.redirect_pc = 64'd0; bus.resolve_valid = 1'b0;
    m_pc = RESET_PC; m_last = 64'd0; m_last_v = 1'b0;

    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("reset_q_count", 64'(bus.q_count), 64'd0);
    check("reset_fv", 64'(bus.fetch_valid), 64'd0);

    // Sequential fetch fills the queue, stalls, then resumes after one resolve.
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 0, 0, 0);
      @(negedge clk);
      check("seq_fv", 64'(bus.fetch_valid), 64'd1);
      check("seq_pc", bus.pc, 64'(4 * i));
    end
    cyc(0, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("stall_fv", 64'(bus.fetch_valid), 64'd0);
    check("stall_pc", bus.pc, 64'h10);
    cyc(0, 1, 0, 0, 0, 1);
    @(negedge clk);
    check("full_count", 64'(bus.q_count), 64'd4);
    check("full_head_pc", bus.q_pc, 64'h0);
    check("full_head_pred", bus.q_pred_pc, 64'h4);
    cyc(0, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("resume_fv", 64'(bus.fetch_valid), 64'd1);
    check("resume_pc", bus.pc, 64'h10);
    check("resume_head", bus.q_pc, 64'h4);

    // Predicted-taken branch: one bubble, entry carries the target.
    cyc(0, 1, 0, 1, 64'h20, 0);
    @(negedge clk);
    check("redir_fv", 64'(bus.fetch_valid), 64'd0);
    cyc(0, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("br_fetch_pc", bus.pc, 64'h20);
    cyc(0, 1, 64'h100, 0, 0, 0);
    @(negedge clk);
    check("br_squash_fv", 64'(bus.fetch_valid), 64'd0);
    cyc(0, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("br_target_pc", bus.pc, 64'h100);
    check("br_target_fv", 64'(bus.fetch_valid), 64'd1);
    check("br_entry_pc", bus.q_pc, 64'h20);
    check("br_entry_pred", bus.q_pred_pc, 64'h100);

    // Prediction equal to fall-through is not a steer.
    cyc(0, 1, 0, 1, 64'h40, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 64'h44, 0, 0, 0);
    @(negedge clk);
    check("nt_fv", 64'(bus.fetch_valid), 64'd1);
    check("nt_pc", bus.pc, 64'h44);
    cyc(0, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("nt_pc2", bus.pc, 64'h48);
    check("nt_entry_pc", bus.q_pc, 64'h40);
    check("nt_entry_pred", bus.q_pred_pc, 64'h44);
    cyc(0, 1, 0, 0, 0, 0);

    // Redirect with three queued entries and a same-cycle resolve.
    cyc(0, 1, 0, 1, 64'h200, 1);
    @(negedge clk);
    check("rd_count_before", 64'(bus.q_count), 64'd3);
    check("rd_cycle_fv", 64'(bus.fetch_valid), 64'd0);
    cyc(0, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("rd_count_after", 64'(bus.q_count), 64'd0);
    check("rd_pc", bus.pc, 64'h200);
    check("rd_fv", 64'(bus.fetch_valid), 64'd1);

    // Simultaneous push and pop at two entries.
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1);
    @(negedge clk);
    check("pp_count", 64'(bus.q_count), 64'd2);
    check("pp_head", bus.q_pc, 64'h200);
    cyc(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("pp_count_after", 64'(bus.q_count), 64'd2);
    check("pp_head_after", bus.q_pc, 64'h204);

    // Resolve on an empty queue is ignored.
    cyc(0, 0, 0, 1, 64'h300, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("empty_res_count", 64'(bus.q_count), 64'd0);
    check("empty_res_pc", bus.pc, 64'h300);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("empty_res_head", bus.q_pc, 64'h300);

    // Reset wins over a simultaneous redirect.
    cyc(1, 1, 0, 1, 64'h500, 0);
    @(negedge clk);
    check("rst_rd_fv", 64'(bus.fetch_valid), 64'd0);
    cyc(1, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("rst_rd_pc", bus.pc, RESET_PC);
    check("rst_rd_count", 64'(bus.q_count), 64'd0);
    cyc(0, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("rst_first_fv", 64'(bus.fetch_valid), 64'd1);
    check("rst_first_pc", bus.pc, RESET_PC);

    // Randomized traffic, including targets near the top of the address space.
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)      pb = 64'd0;
      else if (sel < 6) pb = m_last + 64'd4;
      else if (sel < 9) pb = 64'($urandom_range(0, 4095)) << 2;
      else              pb = 64'hFFFF_FFFF_FFFF_FFFC;
      rpc = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8
                                        : (64'($urandom_range(0, 4095)) << 2);
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), pb,
          ($urandom_range(0, 19) == 0), rpc, ($urandom_range(0, 1) == 1));
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
